// File: rtl/tone_reg_scheduler_pkg.sv
// Shared widths, write-window bounds and register map for the tone register scheduler.
package tone_reg_scheduler_pkg;

  localparam int MCOUNT_W   = 10;
  localparam int REG_ADDR_W = 6;
  localparam int REG_DATA_W = 16;
  localparam int ENTRY_W    = REG_ADDR_W + REG_DATA_W;

  localparam logic [MCOUNT_W-1:0] WIN_OPEN   = 10'h020;
  localparam logic [MCOUNT_W-1:0] WIN_LAST   = 10'h3FE;
  localparam logic [MCOUNT_W-1:0] PARK_COUNT = 10'h040;

  localparam logic [REG_ADDR_W-1:0] ADDR_INCR      = 6'h00;
  localparam logic [REG_ADDR_W-1:0] ADDR_VOLUME    = 6'h04;
  localparam logic [REG_ADDR_W-1:0] ADDR_WAVE_TYPE = 6'h08;
  localparam logic [REG_ADDR_W-1:0] ADDR_LUT       = 6'h20;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wr_entry_t;

  // A pop at this count lands its strobe at count+1, which is always master_id >= 2.
  function automatic logic in_write_window(input logic [MCOUNT_W-1:0] count);
    return (count >= WIN_OPEN) && (count <= WIN_LAST);
  endfunction

endpackage

// File: rtl/tone_reg_scheduler_if.sv
// Host byte-write bus and datapath register-write bus of the tone register scheduler.
interface tone_reg_scheduler_if;
  import tone_reg_scheduler_pkg::*;

  // Host side: a high-byte strobe (host_wr_in with host_addr_in[0]=1) is taken only
  // while host_ready_out=1; low-byte strobes are always taken. Datapath side:
  // data_valid_out is a one-cycle strobe with no backpressure.
  logic                  host_wr_in;
  logic [6:0]            host_addr_in;
  logic [7:0]            host_data_in;
  logic                  host_ready_out;
  logic                  overflow_out;
  logic [MCOUNT_W-1:0]   master_count_out;
  logic [REG_DATA_W-1:0] data_out;
  logic [REG_ADDR_W-1:0] addr_out;
  logic                  data_valid_out;

  modport master (
    output host_wr_in, host_addr_in, host_data_in,
    input  host_ready_out, overflow_out, master_count_out, data_out, addr_out, data_valid_out
  );

  modport slave (
    input  host_wr_in, host_addr_in, host_data_in,
    output host_ready_out, overflow_out, master_count_out, data_out, addr_out, data_valid_out
  );

endinterface

// File: rtl/tone_reg_scheduler_sync_fifo.sv
// Synchronous FIFO with registered occupancy; pointers wrap by natural overflow.
module sync_fifo #(
  parameter int WIDTH = 22,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == FULL_COUNT);
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + {{PTR_W{1'b0}}, w_push} - {{PTR_W{1'b0}}, w_pop};
    end
  end

endmodule

// File: rtl/tone_reg_scheduler.sv
// Master count generator plus host byte assembly and windowed issue of 16-bit
// register writes to the DDS tone datapath.
module tone_reg_scheduler
  import tone_reg_scheduler_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk_in,
  input  logic            reset_in,
  input  logic            enable_in,
  tone_reg_scheduler_if.slave bus
);

  logic [MCOUNT_W-1:0]   r_count;
  logic [7:0]            r_stage;
  logic                  r_overflow;
  logic [REG_DATA_W-1:0] r_data;
  logic [REG_ADDR_W-1:0] r_addr;
  logic                  r_valid;

  logic      w_lo_wr;
  logic      w_hi_wr;
  logic      w_push;
  logic      w_pop;
  logic      w_full;
  logic      w_empty;
  wr_entry_t w_push_entry;
  wr_entry_t w_head;

  assign w_lo_wr = bus.host_wr_in && !bus.host_addr_in[0];
  assign w_hi_wr = bus.host_wr_in &&  bus.host_addr_in[0];
  assign w_push  = w_hi_wr && !w_full;
  assign w_pop   = !w_empty && in_write_window(r_count);

  assign w_push_entry.addr = bus.host_addr_in[6:1];
  assign w_push_entry.data = {bus.host_data_in, r_stage};

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk_in),
    .i_rst   (reset_in),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Parking at master_id 4 keeps the write window open while the count is stopped.
  always_ff @(posedge clk_in) begin
    if (reset_in)       r_count <= '0;
    else if (enable_in) r_count <= r_count + 1'b1;
    else                r_count <= PARK_COUNT;
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_stage    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_lo_wr)           r_stage    <= bus.host_data_in;
      if (w_hi_wr && w_full) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_data  <= '0;
      r_addr  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_pop;
      if (w_pop) begin
        r_data <= w_head.data;
        r_addr <= w_head.addr;
      end
    end
  end

  assign bus.host_ready_out   = !w_full;
  assign bus.overflow_out     = r_overflow;
  assign bus.master_count_out = r_count;
  assign bus.data_out         = r_data;
  assign bus.addr_out         = r_addr;
  assign bus.data_valid_out   = r_valid;

endmodule

// File: tb/tb_tone_reg_scheduler.sv
// Directed bench for tone_reg_scheduler: count wrap, byte assembly, windowed issue,
// overflow, parked count and mid-operation reset.
module tb_tone_reg_scheduler;
  import tone_reg_scheduler_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic en;

  tone_reg_scheduler_if bus ();

  tone_reg_scheduler #(.FIFO_DEPTH(4)) dut (
    .clk_in    (clk),
    .reset_in  (rst),
    .enable_in (en),
    .bus       (bus.slave)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [9:0]  exp_cnt  = '0;
  logic [21:0] exp_q[$];

  // Advance one edge, update the expected count, settle 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    if (rst)     exp_cnt = 10'h000;
    else if (en) exp_cnt = exp_cnt + 10'd1;
    else         exp_cnt = 10'h040;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic host_wr(input logic [5:0] a, input logic hi, input logic [7:0] d);
    bus.host_wr_in   = 1'b1;
    bus.host_addr_in = {a, hi};
    bus.host_data_in = d;
    step();
    bus.host_wr_in   = 1'b0;
  endtask

  // Runs until the expected count reaches tgt; nothing may issue on the way.
  task automatic run_to(input logic [9:0] tgt);
    int k = 0;
    while (exp_cnt != tgt && k < 1100) begin
      step();
      chk("idle_valid", 32'(bus.data_valid_out), 32'h0);
      k++;
    end
    chk("count_at_target", 32'(bus.master_count_out), 32'(tgt));
  endtask

  task automatic expect_pop();
    logic [21:0] e;
    e = exp_q.pop_front();
    chk("pop_valid", 32'(bus.data_valid_out), 32'h1);
    chk("pop_addr",  32'(bus.addr_out), 32'(e[21:16]));
    chk("pop_data",  32'(bus.data_out), 32'(e[15:0]));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    bus.host_wr_in   = 1'b0;
    bus.host_addr_in = '0;
    bus.host_data_in = '0;

    // Reset state
    step();
    rst = 1'b0;
    chk("rst_count",    32'(bus.master_count_out), 32'h000);
    chk("rst_data",     32'(bus.data_out), 32'h0);
    chk("rst_addr",     32'(bus.addr_out), 32'h0);
    chk("rst_valid",    32'(bus.data_valid_out), 32'h0);
    chk("rst_ready",    32'(bus.host_ready_out), 32'h1);
    chk("rst_overflow", 32'(bus.overflow_out), 32'h0);

    // Free-running count with wrap 0x3FF -> 0x000
    for (int i = 1; i <= 1030; i++) begin
      step();
      chk("count_run", 32'(bus.master_count_out), 32'(i % 1024));
      chk("count_run_valid", 32'(bus.data_valid_out), 32'h0);
    end

    // Single assembled write at count 0x100
    run_to(10'h100);
    host_wr(6'h01, 1'b0, 8'h34);
    host_wr(6'h01, 1'b1, 8'h12);
    chk("lat_no_bypass", 32'(bus.data_valid_out), 32'h0);
    step();
    chk("single_valid", 32'(bus.data_valid_out), 32'h1);
    chk("single_data",  32'(bus.data_out), 32'h1234);
    chk("single_addr",  32'(bus.addr_out), 32'h01);
    step();
    chk("single_strobe_len", 32'(bus.data_valid_out), 32'h0);
    chk("single_data_hold",  32'(bus.data_out), 32'h1234);
    chk("single_addr_hold",  32'(bus.addr_out), 32'h01);

    // Three entries held across the closed window, issued at 0x021..0x023
    run_to(10'h3FF);
    host_wr(ADDR_VOLUME, 1'b1, 8'hA1);    exp_q.push_back({ADDR_VOLUME, 8'hA1, 8'h34});
    host_wr(ADDR_WAVE_TYPE, 1'b1, 8'hB2); exp_q.push_back({ADDR_WAVE_TYPE, 8'hB2, 8'h34});
    host_wr(ADDR_LUT, 1'b1, 8'hC3);       exp_q.push_back({ADDR_LUT, 8'hC3, 8'h34});
    run_to(10'h020);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("win_count", 32'(bus.master_count_out), 32'(10'h021 + 10'(i)));
      expect_pop();
    end
    step();
    chk("win_drained", 32'(bus.data_valid_out), 32'h0);

    // Overflow: five high-byte writes into a depth-4 FIFO while closed
    run_to(10'h3FF);
    for (int i = 0; i < 5; i++) begin
      logic [5:0] a;
      a = ADDR_LUT + 6'(i);
      host_wr(a, 1'b1, 8'h50 + 8'(i));
      if (i < 4) exp_q.push_back({a, 8'h50 + 8'(i), 8'h34});
      chk("ovf_ready",    32'(bus.host_ready_out), (i < 3) ? 32'h1 : 32'h0);
      chk("ovf_overflow", 32'(bus.overflow_out),   (i == 4) ? 32'h1 : 32'h0);
    end
    run_to(10'h020);
    for (int i = 0; i < 4; i++) begin
      step();
      expect_pop();
    end
    step();
    chk("ovf_only_four",  32'(bus.data_valid_out), 32'h0);
    chk("ovf_ready_back", 32'(bus.host_ready_out), 32'h1);
    chk("ovf_sticky",     32'(bus.overflow_out), 32'h1);

    // Parked count: window open, queued write issues one edge after its push
    en = 1'b0;
    step();
    chk("park_count", 32'(bus.master_count_out), 32'h040);
    step();
    chk("park_hold", 32'(bus.master_count_out), 32'h040);
    host_wr(ADDR_INCR | 6'h02, 1'b0, 8'hCD);
    host_wr(ADDR_INCR | 6'h02, 1'b1, 8'hAB);
    exp_q.push_back({6'h02, 8'hAB, 8'hCD});
    chk("park_no_bypass", 32'(bus.data_valid_out), 32'h0);
    step();
    expect_pop();
    chk("park_count_still", 32'(bus.master_count_out), 32'h040);
    en = 1'b1;
    step();
    chk("reenable_count", 32'(bus.master_count_out), 32'h041);

    // Reset with two entries pending discards them and the staging byte
    run_to(10'h3FF);
    host_wr(6'h03, 1'b1, 8'h11);
    host_wr(6'h03, 1'b1, 8'h22);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_count",    32'(bus.master_count_out), 32'h000);
    chk("mid_rst_valid",    32'(bus.data_valid_out), 32'h0);
    chk("mid_rst_ready",    32'(bus.host_ready_out), 32'h1);
    chk("mid_rst_overflow", 32'(bus.overflow_out), 32'h0);
    run_to(10'h030);
    host_wr(6'h05, 1'b1, 8'h77);
    exp_q.push_back({6'h05, 8'h77, 8'h00});
    step();
    expect_pop();
    step();
    chk("post_rst_idle", 32'(bus.data_valid_out), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
